serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder: a + b + cin, processed LSB first at one bit per clock.
//  One full-adder cell and a carry flip-flop do all the arithmetic.

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/fa_cell.sv | 14 +
 rtl/serial_adder.sv | 105 ++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells.
// State encodings and the default operand width.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder, add-direction sibling of the subtractor cell.
// Purely combinational.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial a+b+cin adder, LSB first, valid/ready on both sides.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output ovf.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic             s;
    logic             c;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (s),
        .co (c)
    );

    // sum_sh holds partial bits during RUN; only expose it with out_valid
    assign sum = out_valid ? sum_sh : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            carry     <= 1'b0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= a;
                        b_sh     <= b;
                        carry    <= cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {s, sum_sh[WIDTH-1:1]};
                    carry  <= c;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        cout      <= c;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry into the MSB differs from carry out
                        ovf       <= carry ^ c;
`endif
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8).
// Table vectors, random ops vs arithmetic model, handshake corners.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks;
    int failures;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from operand signs
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                         input logic mc, output logic [W-1:0] ms,
                         output logic mco, output logic mo);
        logic [W:0] t;
        t   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ms  = t[W-1:0];
        mco = t[W];
        mo  = (ma[W-1] == mb[W-1]) && (ms[W-1] != ma[W-1]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input bit early,
                          output logic [W-1:0] rs, output logic rc,
                          output logic ro, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        check("wait_in_ready", {31'd0, in_ready}, 32'd1);
        a         = ta;
        b         = tb;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = early;
        tick();
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = 1'($urandom);
        lat      = 1;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        rs        = sum;
        rc        = cout;
        ro        = ovf;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic verify(input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb, input logic tc,
                          input logic [W-1:0] rs, input logic rc,
                          input logic ro, input int lat);
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        model(ta, tb, tc, es, ec, eo);
        check({tag, "_sum"}, {24'd0, rs}, {24'd0, es});
        check({tag, "_cout"}, {31'd0, rc}, {31'd0, ec});
        check({tag, "_lat"}, lat, W + 1);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, {31'd0, ro}, {31'd0, eo});
`else
        if (ro !== 1'b0) check({tag, "_ovf"}, {31'd0, ro}, 32'd0);
`endif
    endtask

    initial begin
        vec_t         vecs[7];
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        int           lat;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rci;
        logic [W-1:0] es;
        logic         ec;
        logic         eo;
        int           n;
        bit           seen;

        checks    = 0;
        failures  = 0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        vecs[0] = '{8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h0A, 8'h14, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};

        rst_n = 1'b0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'd0);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, rs, rc, ro, lat);
            check($sformatf("vec%0d_sum", i), {24'd0, rs}, {24'd0, vecs[i].sum});
            check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].cout});
            check($sformatf("vec%0d_lat", i), lat, 9);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("vec%0d_ovf", i), {31'd0, ro}, {31'd0, vecs[i].ovf});
`endif
        end

        for (int i = 0; i < 30; i++) begin
            ra  = W'($urandom);
            rb  = W'($urandom);
            rci = 1'($urandom);
            run_op(ra, rb, rci, i[0], rs, rc, ro, lat);
            verify($sformatf("rnd%0d", i), ra, rb, rci, rs, rc, ro, lat);
        end

        // Back-pressure: hold result for 5 cycles, in_valid in DONE ignored
        model(8'hC3, 8'h5A, 1'b1, es, ec, eo);
        a = 8'hC3; b = 8'h5A; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        a = 8'h01; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_sum", {24'd0, sum}, {24'd0, es});
            check("bp_cout", {31'd0, cout}, {31'd0, ec});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Second operand set pulsed during RUN must be dropped
        model(8'h21, 8'h42, 1'b0, es, ec, eo);
        a = 8'h21; b = 8'h42; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        a = 8'h01; b = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        check("run_ign_sum", {24'd0, sum}, {24'd0, es});
        check("run_ign_cout", {31'd0, cout}, {31'd0, ec});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("run_ign_no_second", {31'd0, seen}, 32'd0);
        check("run_ign_idle", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of RUN aborts with no result
        a = 8'h55; b = 8'h66; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_sum", {24'd0, sum}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check("abort_no_result", {31'd0, seen}, 32'd0);
        run_op(8'd10, 8'd20, 1'b0, 1'b0, rs, rc, ro, lat);
        check("abort_after_sum", {24'd0, rs}, 32'd30);
        check("abort_after_cout", {31'd0, rc}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
